taxi_ctrl_fsm: RTL
==================

// Module: taxi_ctrl_fsm
// PURPOSE
//  Trip sequencer feeding the 2-bit state input of the price meter. Converts driver buttons
//  and the wheel-sensor pulse into IDLE/MOVE/WAIT, adds a SETTLE hold so the locked fare is
//  shown before the next trip, and emits a one-cycle fare_lock strobe. Runs on the 10 Hz meter clock.
// PARAMETERS
//  STALL_TICKS   30  MOVE cycles with no wheel_pulse before auto-WAIT (3 s @10 Hz); >=2
//  SETTLE_TICKS  50  cycles held in SETTLE before returning to IDLE (5 s); >=2
//  CNT_W         8   width of stall/settle counters; 2**CNT_W > max(STALL_TICKS,SETTLE_TICKS)
// PORTS
//  clk          in   1   clock, rising edge, single clock domain
//  rst          in   1   synchronous reset, active-high
//  btn_start    in   1   start trip (level, debounced externally)
//  btn_pause    in   1   manual MOVE<->WAIT toggle (level)
//  btn_end      in   1   end trip (level)
//  wheel_pulse  in   1   one-cycle pulse per wheel revolution
//  state        out  2   meter state: IDLE=2'b00, MOVE=2'b01, WAIT=2'b11 (never 2'b10)
//  fare_lock    out  1   one-cycle strobe on entry to SETTLE
//  trip_active  out  1   high in MOVE or WAIT
//  settle_busy  out  1   high in SETTLE
// BEHAVIOUR
//  - Internal FSM: S_IDLE, S_MOVE, S_WAIT, S_SETTLE. Output state registered; S_SETTLE drives 2'b00.
//  - Buttons rising-edge detected internally; edge flops reset to 1, so a button held through
//    reset fires only after release and re-press. Edge sampled at edge N -> new state at edge N+1.
//  - Reset: FSM=S_IDLE, state=00, fare_lock=0, trip_active=0, settle_busy=0, counters=0.
//    Reset mid-trip aborts silently: no fare_lock pulse.
//  - Transitions (priority end > start > pause > wheel/stall, one transition per cycle):
//    S_IDLE:   start -> S_MOVE; end/pause/wheel ignored.
//    S_MOVE:   end -> S_SETTLE; pause -> S_WAIT; stall expiry -> S_WAIT (AUTOWAIT only).
//    S_WAIT:   end -> S_SETTLE; pause -> S_MOVE; wheel_pulse -> S_MOVE (AUTOWAIT only).
//    S_SETTLE: settle expiry -> S_IDLE; start, pause, end ignored.
//  - Stall counter: cleared on MOVE entry and on every wheel_pulse in MOVE; else increments;
//    expiry when value==STALL_TICKS-1 with no pulse that cycle. Held at 0 outside MOVE.
//  - Settle counter: cleared on SETTLE entry, increments; expiry at SETTLE_TICKS-1, so SETTLE
//    lasts exactly SETTLE_TICKS cycles. Held at 0 outside SETTLE. Counters never wrap.
//  - fare_lock high exactly the first cycle FSM is S_SETTLE (registered with state).
//  - start in MOVE/WAIT ignored (no restart mid-trip). Same-cycle end+pause: end wins.
// CONFIGURATION
//  TAXI_AUTOWAIT_EN defined: stall-timer MOVE->WAIT and wheel_pulse WAIT->MOVE as above.
//  Not defined: stall counter and wheel_pulse logic removed; WAIT entered/left only via btn_pause;
//  wheel_pulse port kept but ignored; STALL_TICKS unused.
// STRUCTURE
//  taxi_pkg: state codes ST_IDLE/ST_MOVE/ST_WAIT (match meter), FSM enum S_IDLE..S_SETTLE,
//  function mapping FSM enum -> 2-bit state code.
//  Sub-module btn_edge (1-bit rising-edge detector, sync active-high rst, reset value 1),
//  instantiated three times. FSM + counters stay in taxi_ctrl_fsm.
// TESTING
//  1 Reset with btn_start held high, release, press 1 cycle -> state 00 until press, 01 one cycle later.
//  2 MOVE, btn_pause pulse -> 11; pulse again -> 01; end+pause same cycle -> 00, fare_lock 1 cycle.
//  3 AUTOWAIT, STALL_TICKS=30: MOVE, no wheel -> state 11 exactly 30 cycles after MOVE entry;
//    wheel_pulse at cycle 29 restarts count; wheel_pulse in WAIT -> 01 next cycle.
//  4 btn_end in MOVE -> fare_lock 1 cycle, settle_busy 50 cycles, btn_start during SETTLE ignored,
//    then IDLE; start after -> MOVE.
//  5 rst asserted in WAIT -> next cycle state 00, fare_lock 0, settle_busy 0, trip_active 0.
//  6 Without TAXI_AUTOWAIT_EN: 100 cycles MOVE with no wheel -> stays 01; wheel in WAIT -> stays 11.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared definitions for the taxi trip sequencer: meter state codes, FSM encoding
// and the mapping between them.
package taxi_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MOVE = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } fsm_t;

    // SETTLE looks like IDLE to the meter so the locked fare stays frozen.
    function automatic logic [1:0] state_code(input fsm_t s);
        logic [1:0] code;
        case (s)
            S_IDLE:   code = ST_IDLE;
            S_MOVE:   code = ST_MOVE;
            S_WAIT:   code = ST_WAIT;
            S_SETTLE: code = ST_IDLE;
            default:  code = ST_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level. The history flop
// resets high so a button held through reset must be released and pressed again.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev_r;
    logic rise_r;

    // History flop and registered rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b1;
            rise_r <= 1'b0;
        end else begin
            prev_r <= btn;
            rise_r <= btn & ~prev_r;
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/taxi_ctrl_fsm.sv
// Taxi trip sequencer driving the price meter state input (IDLE/MOVE/WAIT + SETTLE hold).
// Define TAXI_AUTOWAIT_EN to enable stall-timer auto-WAIT and wheel-pulse resume.
module taxi_ctrl_fsm
    import taxi_pkg::*;
#(
    parameter int unsigned STALL_TICKS  = 30,
    parameter int unsigned SETTLE_TICKS = 50,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_end,
    input  logic       wheel_pulse,
    output logic [1:0] state,
    output logic       fare_lock,
    output logic       trip_active,
    output logic       settle_busy
);

    logic start_rise_s;
    logic pause_rise_s;
    logic end_rise_s;

    btn_edge u_edge_start (.clk(clk), .rst(rst), .btn(btn_start), .rise(start_rise_s));
    btn_edge u_edge_pause (.clk(clk), .rst(rst), .btn(btn_pause), .rise(pause_rise_s));
    btn_edge u_edge_end   (.clk(clk), .rst(rst), .btn(btn_end),   .rise(end_rise_s));

    fsm_t             fsm_r;
    fsm_t             fsm_nxt_s;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             settle_exp_s;
    logic [1:0]       state_r;
    logic             fare_lock_r;
    logic             trip_active_r;
    logic             settle_busy_r;
    logic [1:0]       state_nxt_s;
    logic             fare_lock_nxt_s;
    logic             trip_active_nxt_s;
    logic             settle_busy_nxt_s;

    assign settle_exp_s = (settle_cnt_r == CNT_W'(SETTLE_TICKS - 1));

`ifdef TAXI_AUTOWAIT_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic             stall_exp_s;

    assign stall_exp_s = (stall_cnt_r == CNT_W'(STALL_TICKS - 1)) && !wheel_pulse;

    // Stall counter: runs only while staying in MOVE without a wheel pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if ((fsm_r == S_MOVE) && (fsm_nxt_s == S_MOVE) && !wheel_pulse) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end
    end
`else
    logic unused_s;
    assign unused_s = wheel_pulse | (STALL_TICKS == 32'd0);
`endif

    // State register, settle counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_r         <= S_IDLE;
            settle_cnt_r  <= {CNT_W{1'b0}};
            state_r       <= ST_IDLE;
            fare_lock_r   <= 1'b0;
            trip_active_r <= 1'b0;
            settle_busy_r <= 1'b0;
        end else begin
            fsm_r         <= fsm_nxt_s;
            state_r       <= state_nxt_s;
            fare_lock_r   <= fare_lock_nxt_s;
            trip_active_r <= trip_active_nxt_s;
            settle_busy_r <= settle_busy_nxt_s;
            if ((fsm_r == S_SETTLE) && (fsm_nxt_s == S_SETTLE)) begin
                settle_cnt_r <= settle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                settle_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Next-state logic; priority end > start > pause > wheel/stall.
    always_comb begin
        fsm_nxt_s = fsm_r;
        case (fsm_r)
            S_IDLE: begin
                if (start_rise_s) fsm_nxt_s = S_MOVE;
                else              fsm_nxt_s = S_IDLE;
            end
            S_MOVE: begin
                if (end_rise_s)        fsm_nxt_s = S_SETTLE;
                else if (pause_rise_s) fsm_nxt_s = S_WAIT;
`ifdef TAXI_AUTOWAIT_EN
                else if (stall_exp_s)  fsm_nxt_s = S_WAIT;
`endif
                else                   fsm_nxt_s = S_MOVE;
            end
            S_WAIT: begin
                if (end_rise_s)        fsm_nxt_s = S_SETTLE;
                else if (pause_rise_s) fsm_nxt_s = S_MOVE;
`ifdef TAXI_AUTOWAIT_EN
                else if (wheel_pulse)  fsm_nxt_s = S_MOVE;
`endif
                else                   fsm_nxt_s = S_WAIT;
            end
            S_SETTLE: begin
                if (settle_exp_s) fsm_nxt_s = S_IDLE;
                else              fsm_nxt_s = S_SETTLE;
            end
            default: fsm_nxt_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so outputs register alongside the FSM.
    always_comb begin
        state_nxt_s       = state_code(fsm_nxt_s);
        fare_lock_nxt_s   = (fsm_nxt_s == S_SETTLE) && (fsm_r != S_SETTLE);
        trip_active_nxt_s = (fsm_nxt_s == S_MOVE) || (fsm_nxt_s == S_WAIT);
        settle_busy_nxt_s = (fsm_nxt_s == S_SETTLE);
    end

    assign state       = state_r;
    assign fare_lock   = fare_lock_r;
    assign trip_active = trip_active_r;
    assign settle_busy = settle_busy_r;

endmodule
